vga_rgb_controller: RTL and testbench
=====================================

Name: vga_rgb_controller

Overview:
- Generates 640x480@60 Hz VGA timing from a 100 MHz system clock.
- Drives active-low h_sync/v_sync and 4-bit-per-channel RGB.
- During the visible area, RGB outputs show the static colour set on the r_sw/g_sw/b_sw switch inputs; during blanking they are forced to 0.
- Top-level display block between board switches and the VGA connector.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz pixel rate)
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk  input  1  system clock, 100 MHz; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- r_sw  input  4  red level switches
- g_sw  input  4  green level switches
- b_sw  input  4  blue level switches
- h_sync  output  1  horizontal sync, active low
- v_sync  output  1  vertical sync, active low
- r_port  output  4  red to DAC
- g_port  output  4  green to DAC
- b_port  output  4  blue to DAC

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. Reset is sampled only on the rising clk edge, with no asynchronous path.
- Pixel tick:
  - 2-bit divider counts 0..CLK_DIV-1 and wraps.
  - tick=1 for exactly one clk when divider==CLK_DIV-1, so there is one tick every 4 clks.
- Horizontal counter h_cnt (10 bit):
  - Advances only on tick.
  - Counts 0..H_TOTAL-1, where H_TOTAL = 800, then wraps to 0.
  - Each value is held exactly CLK_DIV clks.
- Vertical counter v_cnt (10 bit):
  - Advances on a tick where h_cnt==H_TOTAL-1.
  - Counts 0..V_TOTAL-1, where V_TOTAL = 525, then wraps to 0.
  - When h_cnt and v_cnt wrap together at the frame end, both return to 0 on the same edge.
- Decode from counters:
  - h_sync_n = 0 iff H_VISIBLE+H_FP <= h_cnt < H_VISIBLE+H_FP+H_SYNC, i.e. 656..751.
  - v_sync_n = 0 iff V_VISIBLE+V_FP <= v_cnt < V_VISIBLE+V_FP+V_SYNC, i.e. 490..491.
  - de = (h_cnt < 640) && (v_cnt < 480).
- Outputs:
  - All five outputs are registered, with 1-clk latency from the counter/switch values.
  - r_port/g_port/b_port = de ? r_sw/g_sw/b_sw : 4'h0.
  - Switches are sampled every clk with no synchroniser. A switch change during the visible area appears on the ports 1 clk later.
- Reset (also when asserted mid-frame):
  - Divider=0, h_cnt=0, v_cnt=0, h_sync=1, v_sync=1, RGB=0.
  - After release, counting restarts from pixel (0,0).
  - The first registered output reflects h_cnt=0, v_cnt=0, which is visible, so RGB = switches.
- Unknown switch inputs are passed through during the visible area; no X-masking.
- Timing totals:
  - Line = 800 px = 3200 clks; frame = 525 lines = 1,680,000 clks.
  - h_sync low for 96 px = 384 clks per line; v_sync low for 2 lines = 6400 clks per frame.

Test Plan:
- Hold reset 1 clk -> h_sync=1, v_sync=1, RGB=0; after release, first output clk has RGB equal to the switches.
- Reset low, sw r=F g=0 b=0 -> r_port=F, g_port=0, b_port=0 for the first 2560 clks of each visible line, then 0 for the 640-clk blanking.
- Count from line start -> h_sync falls 2624 clks (+1 latency) after h_cnt=0 and stays low exactly 384 clks; period is 3200 clks.
- Run a full frame -> v_sync low exactly 6400 clks, starting at line 490; frame period is 1,680,000 clks; RGB=0 throughout lines 480..524.
- Change sw to r=0 g=A b=5 mid-line in the visible area -> ports show 0/A/5 one clk later; ports stay 0 if the change occurs in blanking.
- Assert reset mid-frame (e.g. line 300, pixel 400) -> next clk outputs return to reset values; after release timing restarts at (0,0) with a full 3200-clk first line.

Source files
------------

// File: rtl/vga_rgb_controller.sv
// 640x480@60 Hz VGA timing generator driving a static switch-selected colour.
// Sync pulses are active low; RGB is forced to zero outside the visible area.
module vga_rgb_controller #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] r_sw,
    input  logic [3:0] g_sw,
    input  logic [3:0] b_sw,
    output logic       h_sync,
    output logic       v_sync,
    output logic [3:0] r_port,
    output logic [3:0] g_port,
    output logic [3:0] b_port
);

    localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [1:0] div_q, div_d;
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       h_sync_q, h_sync_d;
    logic       v_sync_q, v_sync_d;
    logic [3:0] r_q, r_d;
    logic [3:0] g_q, g_d;
    logic [3:0] b_q, b_d;
    logic       tick;
    logic       de;

    // Outputs are decoded from the current counters and registered, so the
    // pins lag the counter position by exactly one clk.
    always_comb begin
        tick    = (div_q == DIV_LAST);
        div_d   = tick ? 2'd0 : div_q + 2'd1;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (tick) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = 10'd0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end

        de       = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        h_sync_d = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
        v_sync_d = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
        r_d      = de ? r_sw : 4'h0;
        g_d      = de ? g_sw : 4'h0;
        b_d      = de ? b_sw : 4'h0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= 2'd0;
            h_cnt_q  <= 10'd0;
            v_cnt_q  <= 10'd0;
            h_sync_q <= 1'b1;
            v_sync_q <= 1'b1;
            r_q      <= 4'h0;
            g_q      <= 4'h0;
            b_q      <= 4'h0;
        end else begin
            div_q    <= div_d;
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            h_sync_q <= h_sync_d;
            v_sync_q <= v_sync_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
        end
    end

    assign h_sync = h_sync_q;
    assign v_sync = v_sync_q;
    assign r_port = r_q;
    assign g_port = g_q;
    assign b_port = b_q;

endmodule

// File: tb/tb_vga_rgb_controller.sv
// Directed bench for vga_rgb_controller. Horizontal timing is the real 800-px
// line; the vertical geometry is shrunk to 8 lines so whole frames fit in a short run.
module tb_vga_rgb_controller;

    // Shrunk frame: lines 0..3 visible, 4 front porch, 5..6 sync, 7 back porch.
    localparam int VV  = 4;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] r_sw = 4'h0;
    logic [3:0] g_sw = 4'h0;
    logic [3:0] b_sw = 4'h0;
    logic       h_sync;
    logic       v_sync;
    logic [3:0] r_port;
    logic [3:0] g_port;
    logic [3:0] b_port;

    int checks = 0;
    int errors = 0;
    // n = number of rising edges since the last reset release; the sample after
    // edge n reflects the counter position floor((n-1)/4) pixels into the frame.
    int n = 0;

    always #5 clk = ~clk;

    vga_rgb_controller #(
        .CLK_DIV  (4),
        .H_VISIBLE(640),
        .H_FP     (16),
        .H_SYNC   (96),
        .H_BP     (48),
        .V_VISIBLE(VV),
        .V_FP     (VFP),
        .V_SYNC   (VS),
        .V_BP     (VBP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .r_sw  (r_sw),
        .g_sw  (g_sw),
        .b_sw  (b_sw),
        .h_sync(h_sync),
        .v_sync(v_sync),
        .r_port(r_port),
        .g_port(g_port),
        .b_port(b_port)
    );

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic run_to(input int target);
        while (n < target) step();
    endtask

    task automatic set_sw(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        r_sw = r;
        g_sw = g;
        b_sw = b;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_sw(4'hF, 4'h0, 4'h0);
        step();
        step();
        checks++;
        if (h_sync !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_hsync got %b want 1", h_sync);
        end
        checks++;
        if (v_sync !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_vsync got %b want 1", v_sync);
        end
        checks++;
        if ({r_port, g_port, b_port} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_rgb got %h want 000", {r_port, g_port, b_port});
        end
        reset = 1'b0;
        n = 0;
        step();
        checks++;
        if ({r_port, g_port, b_port} !== 12'hF00) begin
            errors++;
            $display("[TB] FAIL first_pixel_rgb got %h want F00", {r_port, g_port, b_port});
        end
    endtask

    task automatic test_line_timing();
        int   vis = 0;
        int   firstBlank = 0;
        int   hsFall = 0;
        int   hsRise = 0;
        int   hsLow = 0;
        int   vsLow = 0;
        logic prevHs = 1'b1;
        for (int i = 0; i < 3200; i++) begin
            if (i > 0) step();
            if ({r_port, g_port, b_port} === 12'hF00) vis++;
            else if (firstBlank == 0) firstBlank = n;
            if (h_sync === 1'b0) hsLow++;
            if (v_sync !== 1'b1) vsLow++;
            if (prevHs === 1'b1 && h_sync === 1'b0) hsFall = n;
            if (prevHs === 1'b0 && h_sync === 1'b1) hsRise = n;
            prevHs = h_sync;
        end
        checks++;
        if (vis !== 2560) begin
            errors++;
            $display("[TB] FAIL visible_clks got %0d want 2560", vis);
        end
        checks++;
        if (firstBlank !== 2561) begin
            errors++;
            $display("[TB] FAIL first_blank_clk got %0d want 2561", firstBlank);
        end
        checks++;
        if (hsFall !== 2625) begin
            errors++;
            $display("[TB] FAIL hsync_fall got %0d want 2625", hsFall);
        end
        checks++;
        if (hsRise !== 3009) begin
            errors++;
            $display("[TB] FAIL hsync_rise got %0d want 3009", hsRise);
        end
        checks++;
        if (hsLow !== 384) begin
            errors++;
            $display("[TB] FAIL hsync_low_clks got %0d want 384", hsLow);
        end
        checks++;
        if (vsLow !== 0) begin
            errors++;
            $display("[TB] FAIL vsync_line0_low got %0d want 0", vsLow);
        end
        step();
        checks++;
        if ({r_port, g_port, b_port} !== 12'hF00) begin
            errors++;
            $display("[TB] FAIL line1_start_rgb got %h want F00", {r_port, g_port, b_port});
        end
        run_to(5824);
        checks++;
        if (h_sync !== 1'b1) begin
            errors++;
            $display("[TB] FAIL line1_pre_hsync got %b want 1", h_sync);
        end
        step();
        checks++;
        if (h_sync !== 1'b0) begin
            errors++;
            $display("[TB] FAIL line1_hsync_fall got %b want 0", h_sync);
        end
    endtask

    task automatic test_frame();
        int   vsLow = 0;
        int   vsFall = 0;
        int   blankRgb = 0;
        logic prevVs = 1'b1;
        while (n < 25600) begin
            step();
            if (v_sync === 1'b0) vsLow++;
            if (prevVs === 1'b1 && v_sync === 1'b0) vsFall = n;
            prevVs = v_sync;
            if (n > 12800 && {r_port, g_port, b_port} !== 12'h000) blankRgb++;
        end
        checks++;
        if (vsLow !== 6400) begin
            errors++;
            $display("[TB] FAIL vsync_low_clks got %0d want 6400", vsLow);
        end
        checks++;
        if (vsFall !== 16001) begin
            errors++;
            $display("[TB] FAIL vsync_fall got %0d want 16001", vsFall);
        end
        checks++;
        if (blankRgb !== 0) begin
            errors++;
            $display("[TB] FAIL vblank_rgb_nonzero got %0d want 0", blankRgb);
        end
        step();
        checks++;
        if ({r_port, g_port, b_port} !== 12'hF00 || v_sync !== 1'b1) begin
            errors++;
            $display("[TB] FAIL frame_wrap got rgb %h vs %b want F00 1",
                     {r_port, g_port, b_port}, v_sync);
        end
    endtask

    task automatic test_switch_change();
        run_to(25700);
        checks++;
        if ({r_port, g_port, b_port} !== 12'hF00) begin
            errors++;
            $display("[TB] FAIL pre_change_rgb got %h want F00", {r_port, g_port, b_port});
        end
        set_sw(4'h0, 4'hA, 4'h5);
        step();
        checks++;
        if ({r_port, g_port, b_port} !== 12'h0A5) begin
            errors++;
            $display("[TB] FAIL visible_change_rgb got %h want 0A5", {r_port, g_port, b_port});
        end
        run_to(28300);
        set_sw(4'hC, 4'h3, 4'h9);
        step();
        checks++;
        if ({r_port, g_port, b_port} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL blank_change_rgb got %h want 000", {r_port, g_port, b_port});
        end
        run_to(28801);
        checks++;
        if ({r_port, g_port, b_port} !== 12'hC39) begin
            errors++;
            $display("[TB] FAIL next_line_rgb got %h want C39", {r_port, g_port, b_port});
        end
    endtask

    task automatic test_frame_period();
        run_to(41600);
        checks++;
        if (v_sync !== 1'b1) begin
            errors++;
            $display("[TB] FAIL frame2_pre_vsync got %b want 1", v_sync);
        end
        step();
        checks++;
        if (v_sync !== 1'b0) begin
            errors++;
            $display("[TB] FAIL frame2_vsync_fall got %b want 0", v_sync);
        end
    endtask

    task automatic test_mid_reset();
        // Frame 3, line 2, pixel 399: visible with the C39 colour.
        run_to(59200);
        checks++;
        if ({r_port, g_port, b_port} !== 12'hC39) begin
            errors++;
            $display("[TB] FAIL pre_reset_rgb got %h want C39", {r_port, g_port, b_port});
        end
        reset = 1'b1;
        step();
        checks++;
        if ({r_port, g_port, b_port} !== 12'h000 || h_sync !== 1'b1 || v_sync !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs got rgb %h hs %b vs %b want 000 1 1",
                     {r_port, g_port, b_port}, h_sync, v_sync);
        end
        step();
        reset = 1'b0;
        n = 0;
        step();
        checks++;
        if ({r_port, g_port, b_port} !== 12'hC39) begin
            errors++;
            $display("[TB] FAIL restart_first_rgb got %h want C39", {r_port, g_port, b_port});
        end
        run_to(2560);
        checks++;
        if ({r_port, g_port, b_port} !== 12'hC39) begin
            errors++;
            $display("[TB] FAIL restart_last_visible got %h want C39", {r_port, g_port, b_port});
        end
        step();
        checks++;
        if ({r_port, g_port, b_port} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL restart_first_blank got %h want 000", {r_port, g_port, b_port});
        end
        run_to(2624);
        checks++;
        if (h_sync !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart_pre_hsync got %b want 1", h_sync);
        end
        step();
        checks++;
        if (h_sync !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restart_hsync_fall got %b want 0", h_sync);
        end
        run_to(3200);
        checks++;
        if ({r_port, g_port, b_port} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL restart_line_end got %h want 000", {r_port, g_port, b_port});
        end
        step();
        checks++;
        if ({r_port, g_port, b_port} !== 12'hC39 || v_sync !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart_line1 got rgb %h vs %b want C39 1",
                     {r_port, g_port, b_port}, v_sync);
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame();
        test_switch_change();
        test_frame_period();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
